// File: rtl/mcs4_pkg.sv
// mcs4 -- shared types and helpers for the 4004-style instruction cycle.
//   instr_cyc_t    : the eight bus phases A1..X3 of one instruction cycle
//   opr_code_t     : upper nibble (OPR) of an instruction byte
//   accum_opa_t    : OPA values of the accumulator group (OPR=ACCUM_GRP)
//   ioram_opa_t    : OPA values of the I/O and RAM group (OPR=IORAM_GRP)
//   instr_t        : one instruction byte split into OPR/OPA
//   ram_bank_sel_t : bank number selected by DCL
//   cm_ram_decode  : bank number to CM-RAM strobe mask
//   is_two_word    : true when a first word is followed by an operand word
package mcs4;

    typedef enum logic [2:0] {
        A1, A2, A3, M1, M2, X1, X2, X3
    } instr_cyc_t;

    typedef enum logic [3:0] {
        NOP, JCN, FIM_SRC, FIN_JIN, JUN, JMS, INC, ISZ,
        ADD, SUB, LD, XCH, BBL, LDM, IORAM_GRP, ACCUM_GRP
    } opr_code_t;

    typedef enum logic [3:0] {
        CLB, CLC, IAC, CMC, CMA, RAL, RAR, TCC,
        DAC, TCS, STC, DAA, KBP, DCL
    } accum_opa_t;

    typedef enum logic [3:0] {
        WRM, WMP, WRR, WPM, WR0, WR1, WR2, WR3,
        SBM, RDM, RDR, ADM, RD0, RD1, RD2, RD3
    } ioram_opa_t;

    typedef struct packed {
        opr_code_t   opr;
        logic [3:0]  opa;
    } instr_t;

    typedef logic [2:0] ram_bank_sel_t;

    // Bank 0 drives CM-RAM0 alone; banks 1..7 drive CM-RAM3..1 as a binary
    // code, which is simply the bank number shifted up one bit.
    function automatic logic [3:0] cm_ram_decode(input ram_bank_sel_t bank);
        logic [3:0] mask;
        if (bank == 3'd0) begin
            mask = 4'b0001;
        end else begin
            mask = {bank, 1'b0};
        end
        return mask;
    endfunction

    // FIM and FIN share their OPR with SRC and JIN; only the even-OPA forms
    // fetch a second word.
    function automatic logic is_two_word(input instr_t ins);
        logic two;
        case (ins.opr)
            JCN, JUN, JMS, ISZ: two = 1'b1;
            FIM_SRC, FIN_JIN:   two = ~ins.opa[0];
            default:            two = 1'b0;
        endcase
        return two;
    endfunction

endpackage

// File: rtl/mcs4_cycle_ctrl.sv
// mcs4_cycle_ctrl -- 4004-style instruction-cycle controller.
// Steps the eight-phase A1..X3 cycle, puts the fetch address on the bus in
// A1..A3, captures the instruction byte in M1/M2, tracks two-word
// instructions and raises the CM-ROM / CM-RAM command strobes.
//   clk, rst_n   : clock, synchronous active-low reset
//   en_i         : phase-advance enable (0 freezes everything)
//   pc_i         : 12-bit fetch address, sampled on entry to A1
//   bus_i        : ROM nibbles during M1/M2
//   bus_o/_oe_o  : address nibble and its drive enable (A1..A3)
//   acc_i        : accumulator, low three bits become the RAM bank on DCL
//   cyc_o/sync_o : current phase, SYNC high in X3
//   cm_rom_o/cm_ram_o : command strobes
//   instr_o/operand_o : first word / second word of the current instruction
//   instr_vld_o, pc_inc_o : single-advance pulses in X1
//   word2_o      : high for the whole cycle that fetches a second word
module mcs4_cycle_ctrl
    import mcs4::*;
#(
    parameter int CYC_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [11:0] pc_i,
    input  logic [3:0]  bus_i,
    output logic [3:0]  bus_o,
    output logic        bus_oe_o,
    input  logic [3:0]  acc_i,
    output instr_cyc_t  cyc_o,
    output logic        sync_o,
    output logic        cm_rom_o,
    output logic [3:0]  cm_ram_o,
    output instr_t      instr_o,
    output logic [7:0]  operand_o,
    output logic        instr_vld_o,
    output logic        word2_o,
    output logic        pc_inc_o
);

    localparam int DW = (CYC_DIV > 1) ? $clog2(CYC_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CYC_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          adv;
    instr_cyc_t    cyc_nxt;
    logic [11:0]   pc_q;
    logic [3:0]    hi_q;
    instr_t        fetched;
    logic          two_word_pend;
    ram_bank_sel_t bank_q;
    logic          instr_is_src;
    logic          instr_is_dcl;

    assign adv     = en_i && (div_cnt == DIV_LAST);
    assign cyc_nxt = instr_cyc_t'(cyc_o + 3'd1);
    assign fetched = {hi_q, bus_i};

    assign instr_is_src = (instr_o.opr == FIM_SRC) && instr_o.opa[0];
    assign instr_is_dcl = (instr_o.opr == ACCUM_GRP) &&
                          (accum_opa_t'(instr_o.opa) == DCL);

    // Pulses mark the single clock on which X1 is left, so they vanish
    // while the divider is still counting or the enable is low.
    assign pc_inc_o    = adv && (cyc_o == X1);
    assign instr_vld_o = pc_inc_o && !word2_o;

    // Phase divider: counts enabled clocks and wraps on the advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en_i) begin
            if (adv) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Phase FSM with bus and strobe outputs registered for the phase being
    // entered. Reset parks in X3 so the first advance starts a clean A1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_o    <= X3;
            sync_o   <= 1'b1;
            bus_o    <= 4'h0;
            bus_oe_o <= 1'b0;
            cm_rom_o <= 1'b0;
            cm_ram_o <= 4'h0;
            pc_q     <= 12'h000;
        end else if (adv) begin
            cyc_o    <= cyc_nxt;
            sync_o   <= (cyc_nxt == X3);
            bus_o    <= 4'h0;
            bus_oe_o <= 1'b0;
            cm_rom_o <= 1'b0;
            cm_ram_o <= 4'h0;
            case (cyc_nxt)
                A1: begin
                    pc_q     <= pc_i;
                    bus_o    <= pc_i[3:0];
                    bus_oe_o <= 1'b1;
                end
                A2: begin
                    bus_o    <= pc_q[7:4];
                    bus_oe_o <= 1'b1;
                end
                A3: begin
                    bus_o    <= pc_q[11:8];
                    bus_oe_o <= 1'b1;
                    cm_rom_o <= 1'b1;
                    cm_ram_o <= cm_ram_decode(bank_q);
                end
                M2: begin
                    // The OPR nibble is still on the bus here, so decode it live.
                    if (!word2_o && (opr_code_t'(bus_i) == IORAM_GRP)) begin
                        cm_rom_o <= 1'b1;
                        cm_ram_o <= cm_ram_decode(bank_q);
                    end
                end
                X2: begin
                    if (!word2_o && instr_is_src) begin
                        cm_rom_o <= 1'b1;
                        cm_ram_o <= cm_ram_decode(bank_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Fetch, two-word tracking and DCL bank register. A second word only
    // fills operand_o and never arms another two-word sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q          <= 4'h0;
            instr_o       <= '0;
            operand_o     <= 8'h00;
            word2_o       <= 1'b0;
            two_word_pend <= 1'b0;
            bank_q        <= 3'd0;
        end else if (adv) begin
            case (cyc_nxt)
                A1: begin
                    word2_o       <= two_word_pend;
                    two_word_pend <= 1'b0;
                end
                M2: begin
                    hi_q <= bus_i;
                end
                X1: begin
                    if (word2_o) begin
                        operand_o <= fetched;
                    end else begin
                        instr_o       <= fetched;
                        two_word_pend <= is_two_word(fetched);
                    end
                end
                X2: begin
                    if (!word2_o && instr_is_dcl) begin
                        bank_q <= acc_i[2:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
